cic_dec_gain_norm: RTL and testbench

- Parametrised successor to the fixed N=4, max-rate-128 CIC decimator output shifter.
- Computes the CIC bit-gain ceil(N*log2(rate)) at run time using a small multi-cycle state machine, replacing the hard-coded lookup table.
- Normalises the wide CIC output to BW bits through a 2-stage strobed pipeline, with optional rounding and saturation.
- Sits between the CIC decimator comb output and the halfband/DDC output stage.

---
 rtl/cic_dec_gain_norm.sv | 139 +++++++++++++
 tb/tb_cic_dec_gain_norm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_dec_gain_norm.sv
// CIC decimator output normaliser: run-time bit-gain ceil(N*log2(rate)) and a 2-stage strobed shifter.
// Optional rounding with positive saturation is enabled by defining CIC_DEC_GAIN_NORM_ROUND_EN.
module cic_dec_gain_norm #(
  parameter  int BW     = 16,
  parameter  int N      = 4,
  parameter  int RATE_W = 8,
  localparam int GMAX   = N * RATE_W,
  localparam int IW     = BW + GMAX,
  localparam int GW     = $clog2(GMAX + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RATE_W-1:0] rate,
  input  logic              strobe_in,
  input  logic [IW-1:0]     signal_in,
  output logic              strobe_out,
  output logic [BW-1:0]     signal_out,
  output logic [GW-1:0]     shift_out,
  output logic              gain_valid
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, FIND} state_t;

  state_t            state;
  logic [RATE_W-1:0] rate_q;
  logic [GMAX-1:0]   acc;
  logic [GMAX-1:0]   reff_in;
  logic [GMAX-1:0]   reff_q;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     msb;
  logic [GW-1:0]     gain;
  logic              pow2;

  assign reff_in = (rate   == '0) ? GMAX'(1) : GMAX'(rate);
  assign reff_q  = (rate_q == '0) ? GMAX'(1) : GMAX'(rate_q);

  // ceil(log2(acc)): index of the top set bit, bumped unless acc is a power of two
  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < GMAX; i++) begin
      if (acc[i]) msb = GW'(i);
    end
    pow2 = ((acc & (acc - GMAX'(1))) == '0);
    gain = msb + GW'(!pow2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      rate_q     <= '0;
      acc        <= '0;
      cnt        <= '0;
      shift_out  <= '0;
      gain_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rate != rate_q) begin
            state      <= LOAD;
            gain_valid <= 1'b0;
          end
        end
        LOAD: begin
          rate_q <= rate;
          acc    <= reff_in;
          cnt    <= CW'(N - 1);
          state  <= (N == 1) ? FIND : MUL;
        end
        MUL: begin
          if (rate != rate_q) begin
            state <= LOAD;
          end else begin
            acc <= acc * reff_q;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIND;
          end
        end
        FIND: begin
          if (rate != rate_q) begin
            state <= LOAD;
          end else begin
            shift_out  <= gain;
            gain_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  logic              s1_stb;
  logic [IW-1:0]     s1_data;
  logic [GW-1:0]     s1_shift;
  logic [BW-1:0]     norm;

`ifdef CIC_DEC_GAIN_NORM_ROUND_EN
  localparam logic signed [IW:0] SMAX = (IW + 1)'(2 ** (BW - 1) - 1);

  logic [IW:0]        rnd;
  logic signed [IW:0] rsum;
  logic signed [IW:0] rshr;

  // Half-LSB added in one extra bit of headroom; only the positive side can overflow
  always_comb begin
    rnd  = ((IW + 1)'(1) << s1_shift) >> 1;
    rsum = $signed({s1_data[IW-1], s1_data}) + $signed(rnd);
    rshr = rsum >>> s1_shift;
    if (rshr > SMAX) norm = {1'b0, {(BW-1){1'b1}}};
    else             norm = rshr[BW-1:0];
  end
`else
  always_comb begin
    norm = BW'(s1_data >> s1_shift);
  end
`endif

  // Shift is captured with the data so a gain update never splits a sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_stb     <= 1'b0;
      s1_data    <= '0;
      s1_shift   <= '0;
      strobe_out <= 1'b0;
      signal_out <= '0;
    end else begin
      s1_stb <= strobe_in;
      if (strobe_in) begin
        s1_data  <= signal_in;
        s1_shift <= shift_out;
      end
      strobe_out <= s1_stb;
      if (s1_stb) signal_out <= norm;
    end
  end

endmodule

// File: tb/tb_cic_dec_gain_norm.sv
// Self-checking bench for cic_dec_gain_norm: gain FSM latency/abort, datapath shifting, reset flush.
module tb_cic_dec_gain_norm;

  localparam int BW     = 16;
  localparam int N      = 4;
  localparam int RATE_W = 8;
  localparam int GMAX   = N * RATE_W;
  localparam int IW     = BW + GMAX;
  localparam int GW     = $clog2(GMAX + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [RATE_W-1:0] rate;
  logic              strobe_in;
  logic [IW-1:0]     signal_in;
  logic              strobe_out;
  logic [BW-1:0]     signal_out;
  logic [GW-1:0]     shift_out;
  logic              gain_valid;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  int            cur_shift;
  int            cur_rate;
  logic [BW-1:0] hold;
  logic          d1_stb, d2_stb;
  logic [BW-1:0] d1_exp, d2_exp;
  longint        dq[$];

  always #5 clock = ~clock;

  cic_dec_gain_norm #(.BW(BW), .N(N), .RATE_W(RATE_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .signal_in  (signal_in),
    .strobe_out (strobe_out),
    .signal_out (signal_out),
    .shift_out  (shift_out),
    .gain_valid (gain_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Smallest g with 2^g >= max(r,1)^N
  function automatic int ref_gain(input int r);
    longint p = 1;
    int     rr = (r == 0) ? 1 : r;
    int     g = 0;
    for (int i = 0; i < N; i++) p = p * rr;
    while ((longint'(1) << g) < p) g++;
    return g;
  endfunction

  function automatic logic [BW-1:0] ref_norm(input longint x, input int s);
    longint y;
`ifdef CIC_DEC_GAIN_NORM_ROUND_EN
    y = (x + ((s > 0) ? (longint'(1) << (s - 1)) : longint'(0))) >>> s;
    if (y > longint'(2 ** (BW - 1) - 1)) y = longint'(2 ** (BW - 1) - 1);
`else
    y = x >>> s;
`endif
    return BW'(y);
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Rate change from IDLE: one cycle to reach LOAD, then N+1 cycles of computation
  task automatic apply_rate(input int r);
    int g;
    g = ref_gain(r);
    rate = RATE_W'(r);
    repeat (N + 1) tick();
    check("gv_busy", gain_valid, 0);
    tick();
    check("gv_done", gain_valid, 1);
    check("shift", shift_out, g);
    cur_shift = g;
    cur_rate  = r;
  endtask

  // mode 0: ramp k<<shift every cycle; 1: random data with random gaps; 2: directed queue
  task automatic run_stream(input int count, input int mode);
    longint x;
    longint lo;
    logic   stb;
    for (int i = 0; i < count + 2; i++) begin
      check("strobe_out", strobe_out, d2_stb);
      if (d2_stb) hold = d2_exp;
      check("signal_out", signal_out, hold);
      stb = 1'b0;
      x   = 0;
      if (i < count) begin
        case (mode)
          0: begin stb = 1'b1; x = longint'(i) << cur_shift; end
          1: begin
            stb = ($urandom_range(0, 99) < 60);
            lo  = longint'($urandom) & ((longint'(1) << cur_shift) - 1);
            x   = longint'($signed(16'($urandom))) * (longint'(1) << cur_shift) + lo;
          end
          default: begin stb = 1'b1; x = dq[i]; end
        endcase
      end
      d2_stb    = d1_stb;
      d2_exp    = d1_exp;
      d1_stb    = stb;
      d1_exp    = ref_norm(x, cur_shift);
      strobe_in = stb;
      signal_in = IW'(x);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    rate      = 8'd128;
    strobe_in = 1'b0;
    signal_in = '0;
    hold      = '0;
    d1_stb    = 1'b0;
    d2_stb    = 1'b0;
    d1_exp    = '0;
    d2_exp    = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_strobe_out", strobe_out, 0);
    check("rst_signal_out", signal_out, 0);
    check("rst_shift_out", shift_out, 0);
    check("rst_gain_valid", gain_valid, 0);

    @(negedge clock);
    reset = 1'b0;
    repeat (N) tick();
    check("init_gv_busy", gain_valid, 0);
    tick();
    check("init_gv", gain_valid, 1);
    check("init_shift128", shift_out, 28);
    cur_shift = 28;
    cur_rate  = 128;

    apply_rate(3);
    check("shift3", shift_out, 7);
    apply_rate(100);
    check("shift100", shift_out, 27);
    apply_rate(255);
    check("shift255", shift_out, 32);
    apply_rate(1);
    apply_rate(0);
    check("shift0", shift_out, 0);

    // Abort: 64 settled, then 50 started, then 5 while the FSM is multiplying
    apply_rate(64);
    rate = 8'd50;
    tick();
    tick();
    rate = 8'd5;
    for (int i = 0; i < N + 1; i++) begin
      tick();
      check("abort_shift_hold", shift_out, 24);
      check("abort_gv_low", gain_valid, 0);
    end
    tick();
    check("abort_gv", gain_valid, 1);
    check("abort_shift5", shift_out, 10);
    cur_shift = 10;
    cur_rate  = 5;

    for (int k = 0; k < 6; k++) begin
      int r;
      r = $urandom_range(0, 255);
      while (r == cur_rate) r = $urandom_range(0, 255);
      apply_rate(r);
    end

    apply_rate(16);
    run_stream(20, 0);
    run_stream(40, 1);

    apply_rate(2);
    dq = '{longint'(24), -longint'(24), (longint'(16'h7FFF) << 4) | 8,
           -(longint'(32768) << 4), longint'(8), -longint'(8)};
    run_stream(dq.size(), 2);
    run_stream(40, 1);

    // Reset while two strobes are in flight
    strobe_in = 1'b1;
    signal_in = IW'(longint'(100) << cur_shift);
    tick();
    signal_in = IW'(longint'(200) << cur_shift);
    tick();
    reset     = 1'b1;
    strobe_in = 1'b0;
    #1;
    check("mid_rst_strobe_out", strobe_out, 0);
    check("mid_rst_signal_out", signal_out, 0);
    check("mid_rst_gain_valid", gain_valid, 0);
    @(negedge clock);
    reset  = 1'b0;
    hold   = '0;
    d1_stb = 1'b0;
    d2_stb = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      check("post_rst_gv_busy", gain_valid, 0);
      check("post_rst_no_strobe", strobe_out, 0);
    end
    tick();
    check("post_rst_gv", gain_valid, 1);
    check("post_rst_shift", shift_out, ref_gain(cur_rate));
    cur_shift = ref_gain(cur_rate);
    run_stream(20, 1);

    apply_rate(255);
    run_stream(30, 1);
    apply_rate(1);
    run_stream(30, 1);
    apply_rate(7);
    run_stream(30, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
